// File: rtl/arm_ctrl_pkg.sv
// Shared control definitions for the ARM pipeline: FSM state encoding and
// the bit layout of the pipeline control word carried through the stage registers.
package arm_ctrl_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_REQ  = REQ,
    ST_DONE = DONE
  } state_e;

  // Control word layout: {WB_EN, MEM_R_EN, MEM_W_EN, EXE_CMD[3:0], B, S}
  localparam int CW_S         = 0;
  localparam int CW_B         = 1;
  localparam int CW_EXE_CMD   = 2;
  localparam int EXE_CMD_W    = 4;
  localparam int CW_MEM_W_EN  = CW_EXE_CMD + EXE_CMD_W;
  localparam int CW_MEM_R_EN  = CW_MEM_W_EN + 1;
  localparam int CW_WB_EN     = CW_MEM_R_EN + 1;
  localparam int CW_W         = CW_WB_EN + 1;

  localparam int TMR_W = 8;

  function automatic logic cw_mem_access(input logic [CW_W-1:0] cw);
    return cw[CW_MEM_W_EN] | cw[CW_MEM_R_EN];
  endfunction

endpackage

// File: rtl/ack_timer.sv
// Loadable up-counter that flags the last cycle an SRAM access may wait for
// its acknowledge before the sequencer forces completion.
module ack_timer
  import arm_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [TMR_W-1:0] TC_VAL = TMR_W'(TIMEOUT - 1);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  // Holds at the terminal value so a missed consumer never sees a wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && cnt_q != TC_VAL) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/mem_stall_ctrl.sv
// MEM-stage stall/flush sequencer: runs the SRAM req/ack access and arbitrates
// freeze against branch flush and ID hazard stall. Optional macro: STALL_CNT_EN.
module mem_stall_ctrl
  import arm_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_r_en,
  input  logic             mem_w_en,
  input  logic             mem_ack,
  input  logic             b_taken,
  input  logic             hazard,
  output logic             mem_req,
  output logic             mem_we,
  output logic             freeze,
  output logic             stall_id,
  output logic             flush,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt
);

  // Handshake: mem_req is a level raised the cycle after the enable is seen and
  // held until a one-cycle mem_ack (or the timeout) completes it; mem_we is
  // latched at request start and stable for the whole request.
  state_e state_q, state_d;
  logic   mem_we_q, mem_we_d;
  logic   err_q, err_d;
  logic   mem_en, start, in_req, tmr_tc;
  logic   freeze_c, stall_c, flush_c;

  assign mem_en = mem_r_en | mem_w_en;
  assign in_req = (state_q == ST_REQ);
  assign start  = (state_q == ST_IDLE) & mem_en;

  ack_timer #(.TIMEOUT(TIMEOUT)) u_ack_timer (
    .clk (clk),
    .rst (rst),
    .clr (start),
    .en  (in_req),
    .tc  (tmr_tc)
  );

  always_comb begin
    state_d  = state_q;
    mem_we_d = mem_we_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_en) begin
          state_d  = ST_REQ;
          mem_we_d = mem_w_en;
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          state_d = ST_DONE;
        end else if (tmr_tc) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mem_we_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mem_we_q <= mem_we_d;
      err_q    <= err_d;
    end
  end

  // Freeze covers the enable cycle itself; flush beats stall, freeze beats both.
  assign freeze_c = ~rst & (start | in_req);
  assign flush_c  = ~rst & ~freeze_c & b_taken;
  assign stall_c  = ~rst & ~freeze_c & hazard & ~b_taken;

  assign mem_req  = in_req;
  assign mem_we   = mem_we_q;
  assign freeze   = freeze_c;
  assign flush    = flush_c;
  assign stall_id = stall_c;
  assign busy     = (state_q != ST_IDLE);
  assign err      = err_q;

`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if ((freeze_c | stall_c) && cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Directed bench for mem_stall_ctrl (TIMEOUT=4, CNT_W=4); inputs change 1ns
// after the rising edge and outputs are sampled on the falling edge.
module tb_mem_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mem_r_en = 1'b0, mem_w_en = 1'b0, mem_ack = 1'b0;
  logic       b_taken = 1'b0, hazard = 1'b0;
  logic       mem_req, mem_we, freeze, stall_id, flush, busy, err;
  logic [3:0] stall_cnt;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_stall_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_r_en  (mem_r_en),
    .mem_w_en  (mem_w_en),
    .mem_ack   (mem_ack),
    .b_taken   (b_taken),
    .hazard    (hazard),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .freeze    (freeze),
    .stall_id  (stall_id),
    .flush     (flush),
    .busy      (busy),
    .err       (err),
    .stall_cnt (stall_cnt)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    mem_r_en = 1'b0; mem_w_en = 1'b0; mem_ack = 1'b0;
    b_taken = 1'b0; hazard = 1'b0;
  endtask

  task automatic test_reset();
    logic [10:0] all_out;
    mem_r_en = 1'b1; mem_w_en = 1'b1; mem_ack = 1'b1; b_taken = 1'b1; hazard = 1'b1;
    #2;
    all_out = {mem_req, mem_we, freeze, stall_id, flush, busy, err, stall_cnt};
    n_chk++;
    if (all_out !== 11'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %b want %b", all_out, 11'd0);
    end
    @(negedge clk);
    all_out = {mem_req, mem_we, freeze, stall_id, flush, busy, err, stall_cnt};
    n_chk++;
    if (all_out !== 11'd0) begin
      n_fail++; $display("FAIL reset_held: got %b want %b", all_out, 11'd0);
    end
    next_cycle();
    clear_inputs();
    rst = 1'b0;
    @(negedge clk);
    all_out = {mem_req, mem_we, freeze, stall_id, flush, busy, err, stall_cnt};
    n_chk++;
    if (all_out !== 11'd0) begin
      n_fail++; $display("FAIL reset_release: got %b want %b", all_out, 11'd0);
    end
    next_cycle();
  endtask

  // Load, ack in the third REQ cycle. Columns {freeze, mem_req, busy}.
  task automatic test_load();
    logic [2:0] e [6] = '{3'b100, 3'b111, 3'b111, 3'b111, 3'b001, 3'b000};
    logic [2:0] got;
    for (int c = 0; c < 6; c++) begin
      mem_r_en = (c < 5);
      mem_ack  = (c == 3);
      @(negedge clk);
      got = {freeze, mem_req, busy};
      n_chk++;
      if (got !== e[c]) begin
        n_fail++; $display("FAIL load_seq c%0d: got %b want %b", c, got, e[c]);
      end
      if (c == 2) begin
        n_chk++;
        if (mem_we !== 1'b0) begin
          n_fail++; $display("FAIL load_we: got %b want 0", mem_we);
        end
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  // Store then load, each acked in its first REQ cycle.
  task automatic test_back_to_back();
    logic [2:0] e [7] = '{3'b100, 3'b111, 3'b001, 3'b100, 3'b111, 3'b001, 3'b000};
    logic [2:0] got;
    int pulses = 0;
    for (int c = 0; c < 7; c++) begin
      mem_w_en = (c < 3);
      mem_r_en = (c >= 3 && c < 6);
      mem_ack  = (c == 1 || c == 4);
      @(negedge clk);
      got = {freeze, mem_req, busy};
      if (mem_req === 1'b1) pulses++;
      n_chk++;
      if (got !== e[c]) begin
        n_fail++; $display("FAIL b2b_seq c%0d: got %b want %b", c, got, e[c]);
      end
      if (c == 1 || c == 4) begin
        n_chk++;
        if (mem_we !== (c == 1)) begin
          n_fail++; $display("FAIL b2b_we c%0d: got %b want %b", c, mem_we, (c == 1));
        end
      end
      next_cycle();
    end
    clear_inputs();
    n_chk++;
    if (pulses != 2) begin
      n_fail++; $display("FAIL b2b_pulses: got %0d want 2", pulses);
    end
  endtask

  // Both enables high latch a write; enables glitch during REQ; stray ack in IDLE.
  task automatic test_we_hold();
    logic [2:0] e [7] = '{3'b100, 3'b111, 3'b111, 3'b001, 3'b000, 3'b000, 3'b000};
    logic [2:0] got;
    for (int c = 0; c < 7; c++) begin
      mem_r_en = (c < 4);
      mem_w_en = (c == 0);
      mem_ack  = (c == 2 || c == 5);
      @(negedge clk);
      got = {freeze, mem_req, busy};
      n_chk++;
      if (got !== e[c]) begin
        n_fail++; $display("FAIL we_hold_seq c%0d: got %b want %b", c, got, e[c]);
      end
      if (c == 1 || c == 2) begin
        n_chk++;
        if (mem_we !== 1'b1) begin
          n_fail++; $display("FAIL we_hold_we c%0d: got %b want 1", c, mem_we);
        end
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  // Ack arrives in the terminal-count cycle: completion by ack, no error.
  task automatic test_ack_at_tc();
    logic [3:0] e [7] = '{4'b1000, 4'b1110, 4'b1110, 4'b1110, 4'b1110, 4'b0010, 4'b0000};
    logic [3:0] got;
    for (int c = 0; c < 7; c++) begin
      mem_r_en = (c < 6);
      mem_ack  = (c == 4);
      @(negedge clk);
      got = {freeze, mem_req, busy, err};
      n_chk++;
      if (got !== e[c]) begin
        n_fail++; $display("FAIL ack_tc_seq c%0d: got %b want %b", c, got, e[c]);
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_branch();
    logic [2:0] e [5] = '{3'b001, 3'b001, 3'b001, 3'b100, 3'b100};
    logic [2:0] got;
    logic [1:0] fs;
    b_taken = 1'b1; hazard = 1'b1;
    @(negedge clk);
    fs = {flush, stall_id};
    n_chk++;
    if (fs !== 2'b10) begin
      n_fail++; $display("FAIL branch_both: got %b want 10", fs);
    end
    next_cycle();
    b_taken = 1'b0;
    @(negedge clk);
    fs = {flush, stall_id};
    n_chk++;
    if (fs !== 2'b01) begin
      n_fail++; $display("FAIL hazard_only: got %b want 01", fs);
    end
    next_cycle();
    // Columns {flush, stall_id, freeze} while a load is in flight.
    b_taken = 1'b1;
    for (int c = 0; c < 5; c++) begin
      mem_r_en = (c < 4);
      mem_ack  = (c == 2);
      @(negedge clk);
      got = {flush, stall_id, freeze};
      n_chk++;
      if (got !== e[c]) begin
        n_fail++; $display("FAIL branch_frozen c%0d: got %b want %b", c, got, e[c]);
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_timeout();
    logic [3:0] e [7] = '{4'b1000, 4'b1110, 4'b1110, 4'b1110, 4'b1110, 4'b0011, 4'b0001};
    logic [3:0] e2 [4] = '{4'b1001, 4'b1111, 4'b0011, 4'b0001};
    logic [3:0] got;
    for (int c = 0; c < 7; c++) begin
      mem_r_en = (c < 6);
      @(negedge clk);
      got = {freeze, mem_req, busy, err};
      n_chk++;
      if (got !== e[c]) begin
        n_fail++; $display("FAIL timeout_seq c%0d: got %b want %b", c, got, e[c]);
      end
      next_cycle();
    end
    for (int c = 0; c < 4; c++) begin
      mem_w_en = (c < 3);
      mem_ack  = (c == 1);
      @(negedge clk);
      got = {freeze, mem_req, busy, err};
      n_chk++;
      if (got !== e2[c]) begin
        n_fail++; $display("FAIL err_sticky c%0d: got %b want %b", c, got, e2[c]);
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_req();
    logic [3:0] got;
    mem_r_en = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    n_chk++;
    if (mem_req !== 1'b1) begin
      n_fail++; $display("FAIL mid_req_pre: got %b want 1", mem_req);
    end
    #2 rst = 1'b1;
    #1;
    got = {mem_req, freeze, busy, err};
    n_chk++;
    if (got !== 4'b0000) begin
      n_fail++; $display("FAIL mid_req_async: got %b want 0000", got);
    end
    next_cycle();
    rst = 1'b0;
    mem_r_en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      got = {mem_req, freeze, busy, err};
      n_chk++;
      if (got !== 4'b0000) begin
        n_fail++; $display("FAIL mid_req_after c%0d: got %b want 0000", c, got);
      end
      next_cycle();
    end
  endtask

  task automatic test_stall_cnt();
    logic [3:0] exp5, exp20;
`ifdef STALL_CNT_EN
    exp5 = 4'd5; exp20 = 4'd15;
`else
    exp5 = 4'd0; exp20 = 4'd0;
`endif
    rst = 1'b1;
    #2;
    rst = 1'b0;
    hazard = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      next_cycle();
      if (i == 5) begin
        n_chk++;
        if (stall_cnt !== exp5) begin
          n_fail++; $display("FAIL stall_cnt_5: got %0d want %0d", stall_cnt, exp5);
        end
      end
    end
    n_chk++;
    if (stall_cnt !== exp20) begin
      n_fail++; $display("FAIL stall_cnt_20: got %0d want %0d", stall_cnt, exp20);
    end
    clear_inputs();
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_load();
    test_back_to_back();
    test_we_hold();
    test_ack_at_tc();
    test_branch();
    test_timeout();
    test_reset_mid_req();
    test_stall_cnt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, want completion");
    $fatal(1);
  end

endmodule

// File: doc/mem_stall_ctrl.md
# mem_stall_ctrl

Pipeline stall and flush sequencer for the 5-stage ARM core. It watches the MEM-stage memory enables and sequences a request/acknowledge access to the external SRAM controller, freezing the whole pipeline until the access completes. It also arbitrates the global freeze against branch flush and ID-stage hazard stall, so every pipeline register gets exactly one hold/clear decision per cycle.

## Interface
- TIMEOUT, 64: max REQ cycles without ack before forced completion (2..255)
- CNT_W, 16: width of stall counter
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- mem_r_en  in  1  MEM-stage load enable
- mem_w_en  in  1  MEM-stage store enable
- mem_ack  in  1  SRAM controller completion, one-cycle pulse
- b_taken  in  1  branch taken, resolved in EXE
- hazard  in  1  data hazard from hazard unit (ID stage)
- mem_req  out  1  SRAM access request, level, held until ack/timeout
- mem_we  out  1  write qualifier, valid while mem_req=1
- freeze  out  1  hold PC and all pipeline registers
- stall_id  out  1  hold PC and IF/ID, bubble into ID/EXE
- flush  out  1  clear IF/ID and ID/EXE
- busy  out  1  FSM not in IDLE
- err  out  1  sticky: a timeout has occurred
- stall_cnt  out  CNT_W  stall-cycle count

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE: if mem_r_en|mem_w_en, go to REQ and latch mem_we = mem_w_en. freeze is asserted combinationally in this same cycle.
- REQ:
  - mem_req=1 and freeze=1.
  - mem_ack=1 goes to DONE.
  - If the timeout counter reaches TIMEOUT-1 without ack, go to DONE and set err.
- DONE: freeze=0 for exactly one cycle so the MEM instruction advances into MEM/WB. Always goes to IDLE, and the enables are not re-evaluated in DONE.
- Both enables high (illegal): treated as a write, so mem_we=1.
- mem_ack outside REQ is ignored.
- mem_we is latched and held stable for the whole of REQ, even if inputs glitch.
- Priority when freeze=0: flush=b_taken; stall_id=hazard & ~b_taken (flush wins).
- When freeze=1, flush and stall_id are forced to 0. The frozen EXE stage re-presents b_taken after release.
- Timeout counter: clears on REQ entry and increments each REQ cycle.
- err: cleared only by rst.

## Timing
- Reset values: state=IDLE, mem_req=0, mem_we=0, freeze=0, stall_id=0, flush=0, busy=0, err=0, stall_cnt=0.
- The reset values hold combinationally-low outputs low regardless of inputs while rst=1.
- Cycle 0 (IDLE, enable seen): freeze=1, mem_req=0.
- Cycle 1: REQ, mem_req=1.
- Ack in cycle k≥1: DONE in k+1 with freeze=0, then IDLE in k+2.
- Minimum freeze is 2 cycles; total MEM occupancy is ack-cycle+2.
- Back-to-back memory instructions: the second is evaluated in the IDLE cycle after DONE, with no lost or duplicated request.
- Timeout: REQ lasts exactly TIMEOUT cycles, then DONE.
- mem_ack coincident with the timeout terminal count: completion is by ack and err stays 0.
- Reset mid-REQ: mem_req drops asynchronously, the in-flight access is abandoned, and the timer clears.

## Configuration
- STALL_CNT_EN defined: stall_cnt increments on every cycle with freeze|stall_id and saturates at all-ones.
- STALL_CNT_EN undefined: the counter is not built and stall_cnt is tied to 0.

## Structure
- Shared package arm_ctrl_pkg:
  - state encoding localparams (IDLE=2'd0, REQ=2'd1, DONE=2'd2)
  - pipeline control-word bit positions (S, B, EXE_CMD, MEM_W_EN, MEM_R_EN, WB_EN), consumed by the stage registers feeding this block
- One sub-module, ack_timer: loadable up-counter with terminal-count flag, parameterised by TIMEOUT.

## Test plan
- Load, ack 3 cycles after req: mem_r_en=1 → freeze high 4 cycles, mem_req high 3, mem_we=0, DONE one cycle, busy low after.
- Store and load back-to-back, ack in first REQ cycle each: exactly two mem_req pulses of 1 cycle each, second with mem_we=0. Freeze pattern 1,1,0,1,1,0.
- No ack, TIMEOUT=4: mem_req high exactly 4 cycles, then err=1 and stays 1 through later accesses until rst.
- b_taken and hazard both high with no memory op: flush=1, stall_id=0. Same during freeze: both 0 until release, then flush=1.
- rst pulse in 2nd REQ cycle: mem_req, freeze, busy go 0 asynchronously. After release an idle MEM stage gives no request.
- STALL_CNT_EN with CNT_W=4: 20 stall cycles → stall_cnt=15 (saturated). Without the macro, stall_cnt=0 throughout.
